// File: rtl/stripe_scheduler.sv
// ---------------------------------------------------------------------------
// stripe_scheduler
// Sequences a full alignment job through a PE array one PE_NUM-base stripe of
// gene B at a time. For each stripe it fetches the B word, streams gene A
// bases from a_start onward, and uses the array's stripe-end report to pick
// the next stripe's A start point. It also keeps the job-wide max score.
//
// Ports
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_go                  : job start pulse (ignored unless idle)
//   o_busy, o_done        : job in progress / one-cycle end-of-job pulse
//   o_max_score           : job maximum score, updated with o_done
//   o_b_addr, i_b_data    : B memory stripe index / word (1-cycle read latency)
//   o_a_addr, i_a_data    : A memory base address / base (1-cycle read latency)
//   o_pe_start/A/B        : array drive (start, A base, stripe B word)
//   i_pe_stripe_end       : array stripe-end report
//   i_pe_start_position   : array best-alignment start position in A
//   i_pe_max_score        : array stripe max score
// ---------------------------------------------------------------------------
module stripe_scheduler #(
   parameter int unsigned LEN_A   = 1024,
   parameter int unsigned LEN_B   = 1024,
   parameter int unsigned PE_NUM  = 64,
   parameter int unsigned GAP_CYC = 5,
   parameter int unsigned SCORE_W = 14,
   localparam int unsigned NUM_STRIPES = LEN_B / PE_NUM,
   localparam int unsigned B_AW = (NUM_STRIPES > 1) ? $clog2(NUM_STRIPES) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_go,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [SCORE_W-1:0]    o_max_score,
   output logic [B_AW-1:0]       o_b_addr,
   input  logic [2*PE_NUM-1:0]   i_b_data,
   output logic [9:0]            o_a_addr,
   input  logic [1:0]            i_a_data,
   output logic                  o_pe_start,
   output logic [1:0]            o_pe_A,
   output logic [2*PE_NUM-1:0]   o_pe_B,
   input  logic                  i_pe_stripe_end,
   input  logic [9:0]            i_pe_start_position,
   input  logic [SCORE_W-1:0]    i_pe_max_score
);

   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [10:0] A_END = 11'(LEN_A);
   localparam logic [B_AW-1:0] LAST_STRIPE = B_AW'(NUM_STRIPES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_STREAM,
      S_WAIT_END,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state;
   logic               ld_phase;
   logic [GAP_W-1:0]   gap_cnt;
   logic [B_AW-1:0]    stripe;
   logic [10:0]        a_ptr;     // index of the A base currently on i_a_data
   logic [10:0]        a_start;
   logic [SCORE_W-1:0] max_r;

   logic               stripe_end_c;
   logic               present_c;
   logic [10:0]        next_start_c;

   // Stripe end is only meaningful while the array is (or was just) fed.
   assign stripe_end_c = i_pe_stripe_end && (state == S_STREAM || state == S_WAIT_END);

   // Present the base waiting on i_a_data: last LOAD_B cycle, or any STREAM
   // cycle that still has A left. Stripe end takes priority over both.
   assign present_c = (state == S_LOAD_B && ld_phase) ||
                      (state == S_STREAM && a_ptr != A_END);

   assign next_start_c = 11'(i_pe_start_position) + 11'd1;

   // Job sequencer with registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         ld_phase    <= 1'b0;
         gap_cnt     <= '0;
         stripe      <= '0;
         a_ptr       <= '0;
         a_start     <= '0;
         max_r       <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_max_score <= '0;
         o_b_addr    <= '0;
         o_a_addr    <= '0;
         o_pe_start  <= 1'b0;
         o_pe_A      <= '0;
         o_pe_B      <= '0;
      end else begin
         o_done     <= 1'b0;
         o_pe_start <= 1'b0;

         if (stripe_end_c) begin
            // Any prefetched base is dropped simply by not presenting it.
            max_r   <= (i_pe_max_score > max_r) ? i_pe_max_score : max_r;
            a_start <= next_start_c;
            stripe  <= stripe + B_AW'(1);
            if (stripe == LAST_STRIPE || next_start_c >= A_END) begin
               state <= S_DONE;
            end else begin
               state   <= S_GAP;
               gap_cnt <= '0;
            end
         end else if (present_c) begin
            o_pe_start <= 1'b1;
            o_pe_A     <= i_a_data;
            a_ptr      <= a_ptr + 11'd1;
            o_a_addr   <= o_a_addr + 10'd1;
            if (state == S_LOAD_B) begin
               o_pe_B <= i_b_data;
            end
            state <= S_STREAM;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_go) begin
                     stripe   <= '0;
                     a_start  <= '0;
                     max_r    <= '0;
                     a_ptr    <= '0;
                     o_b_addr <= '0;
                     o_a_addr <= '0;
                     ld_phase <= 1'b0;
                     o_busy   <= 1'b1;
                     state    <= S_LOAD_B;
                  end
               end
               S_LOAD_B: begin
                  // First LOAD_B cycle: words are being read; prefetch next A.
                  ld_phase <= 1'b1;
                  o_a_addr <= o_a_addr + 10'd1;
               end
               S_STREAM: begin
                  // Only reached once every A base has been presented.
                  state <= S_WAIT_END;
               end
               S_WAIT_END: begin
               end
               S_GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     o_b_addr <= stripe;
                     o_a_addr <= a_start[9:0];
                     a_ptr    <= a_start;
                     ld_phase <= 1'b0;
                     state    <= S_LOAD_B;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               S_DONE: begin
                  o_done      <= 1'b1;
                  o_busy      <= 1'b0;
                  o_max_score <= max_r;
                  state       <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stripe_scheduler.sv
// ---------------------------------------------------------------------------
// tb_stripe_scheduler
// Scoreboard bench: each job is planned up front (per-stripe run length,
// reported start position and score), the expected base stream, max score
// and final B index are queued, and a negedge monitor compares everything the
// scheduler presents. An array responder raises stripe end per the plan.
// ---------------------------------------------------------------------------
module tb_stripe_scheduler;

   localparam int unsigned LEN_A   = 1024;
   localparam int unsigned LEN_B   = 256;
   localparam int unsigned PE_NUM  = 64;
   localparam int unsigned GAP_CYC = 3;
   localparam int unsigned SCORE_W = 14;
   localparam int unsigned NS      = LEN_B / PE_NUM;
   localparam int unsigned B_AW    = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned BW      = 2 * PE_NUM;

   typedef struct {
      logic [1:0]    a;
      logic [BW-1:0] b;
   } base_t;

   typedef struct {
      int len;
      int pos;
      int score;
   } plan_t;

   logic               clk;
   logic               rst_n;
   logic               go;
   logic               busy;
   logic               done;
   logic [SCORE_W-1:0] max_score;
   logic [B_AW-1:0]    b_addr;
   logic [BW-1:0]      b_data;
   logic [9:0]         a_addr;
   logic [1:0]         a_data;
   logic               pe_start;
   logic [1:0]         pe_a;
   logic [BW-1:0]      pe_b;
   logic               pe_end;
   logic [9:0]         pe_pos;
   logic [SCORE_W-1:0] pe_score;

   stripe_scheduler #(
      .LEN_A(LEN_A), .LEN_B(LEN_B), .PE_NUM(PE_NUM),
      .GAP_CYC(GAP_CYC), .SCORE_W(SCORE_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_go(go),
      .o_busy(busy), .o_done(done), .o_max_score(max_score),
      .o_b_addr(b_addr), .i_b_data(b_data),
      .o_a_addr(a_addr), .i_a_data(a_data),
      .o_pe_start(pe_start), .o_pe_A(pe_a), .o_pe_B(pe_b),
      .i_pe_stripe_end(pe_end), .i_pe_start_position(pe_pos),
      .i_pe_max_score(pe_score)
   );

   logic [1:0]    a_mem [LEN_A];
   logic [BW-1:0] b_mem [NS];

   base_t exp_q[$];
   plan_t plan_q[$];
   int    exp_max_q[$];
   int    exp_baddr_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int end_cyc = 0;
   int end_seq = 0;
   int last_max = 0;

   task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Synchronous-read gene memories.
   initial begin
      a_data = '0;
      b_data = '0;
      forever begin
         @(posedge clk);
         a_data <= a_mem[a_addr];
         b_data <= b_mem[b_addr];
      end
   end

   // PE array responder: ends a stripe after plan.len bases, or 10 cycles
   // after the feed stops if A runs out first.
   initial begin : array_model
      int    cnt;
      int    idle;
      plan_t p;
      cnt      = 0;
      idle     = 0;
      pe_end   = 1'b0;
      pe_pos   = '0;
      pe_score = '0;
      forever begin
         @(negedge clk);
         pe_end = 1'b0;
         if (!rst_n) begin
            cnt  = 0;
            idle = 0;
         end else if (plan_q.size() > 0) begin
            logic raise;
            raise = 1'b0;
            if (pe_start) begin
               cnt++;
               idle = 0;
               if (cnt == plan_q[0].len) raise = 1'b1;
            end else if (cnt > 0) begin
               idle++;
               if (idle == 10) raise = 1'b1;
            end
            if (raise) begin
               p        = plan_q.pop_front();
               pe_end   = 1'b1;
               pe_pos   = 10'(p.pos);
               pe_score = SCORE_W'(p.score);
               cnt      = 0;
               idle     = 0;
               end_cyc  = cyc;
               end_seq++;
            end
         end
      end
   end

   // Monitor: compares every presented base, inter-stripe spacing and job end.
   initial begin : monitor
      base_t e;
      logic  prev_start;
      int    seen_seq;
      int    em;
      int    eb;
      prev_start = 1'b0;
      seen_seq   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_start = 1'b0;
            seen_seq   = end_seq;
         end else begin
            if (pe_start) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_base", BW'(1), BW'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("pe_A", BW'(pe_a), BW'(e.a));
                  check("pe_B", pe_b, e.b);
               end
               if (!prev_start && seen_seq != end_seq) begin
                  check("stripe_gap", BW'(cyc - end_cyc), BW'(GAP_CYC + 3));
                  seen_seq = end_seq;
               end
            end
            if (done) begin
               if (exp_max_q.size() == 0) begin
                  check("unexpected_done", BW'(1), BW'(0));
               end else begin
                  em = exp_max_q.pop_front();
                  eb = exp_baddr_q.pop_front();
                  check("max_score", BW'(max_score), BW'(em));
                  check("final_b_addr", BW'(b_addr), BW'(eb));
               end
               seen_seq = end_seq;
            end
            prev_start = pe_start;
         end
      end
   end

   // Plan one job and queue its expected behaviour.
   // mode 0 random; 1 two-stripe hand-off; 2 max not last; 3 A exhaustion;
   // 4 early termination; 5 end-on-last-base, exhaustion and position 1023.
   task automatic plan_job(input int mode);
      int lens[4];
      int poss[4];
      int scs[4];
      int a_start;
      int mx;
      int avail;
      int len;
      int n;
      int pos;
      int score;
      int last_s;
      base_t bb;
      lens = '{2, 2, 2, 2};
      poss = '{0, 0, 0, 0};
      scs  = '{0, 0, 0, 0};
      case (mode)
         1: begin lens = '{100, 80, 60, 40};  poss = '{99, 200, 300, 400};   scs = '{20, 45, 10, 3};      end
         2: begin lens = '{30, 40, 50, 60};    poss = '{10, 50, 100, 150};    scs = '{50, 12, 30, 7};      end
         3: begin lens = '{2000, 50, 50, 50};  poss = '{500, 600, 700, 800};  scs = '{100, 200, 300, 400}; end
         4: begin lens = '{70, 50, 50, 50};    poss = '{1023, 10, 20, 30};    scs = '{99, 500, 600, 700};  end
         5: begin lens = '{50, 24, 40, 40};    poss = '{999, 1010, 1023, 0};  scs = '{1, 16383, 5, 9};     end
         default: ;
      endcase
      a_start = 0;
      mx      = 0;
      last_s  = 0;
      for (int s = 0; s < int'(NS); s++) begin
         avail = int'(LEN_A) - a_start;
         if (mode == 0) begin
            if ($urandom_range(0, 7) == 0) len = avail + int'($urandom_range(0, 30));
            else                           len = int'($urandom_range(2, 120));
            if (len < 2) len = 2;
            n = (len < avail) ? len : avail;
            if ($urandom_range(0, 9) == 0) pos = 1023;
            else                           pos = a_start + int'($urandom_range(0, n - 1));
            if (pos > 1023) pos = 1023;
            score = int'($urandom_range(0, 16383));
         end else begin
            len   = lens[s];
            pos   = poss[s];
            score = scs[s];
         end
         n = (len < avail) ? len : avail;
         for (int k = 0; k < n; k++) begin
            bb.a = a_mem[a_start + k];
            bb.b = b_mem[s];
            exp_q.push_back(bb);
         end
         plan_q.push_back('{len, pos, score});
         if (score > mx) mx = score;
         last_s  = s;
         a_start = pos + 1;
         if (a_start >= int'(LEN_A)) break;
      end
      exp_max_q.push_back(mx);
      exp_baddr_q.push_back(last_s);
      last_max = mx;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  BW'(busy), BW'(0));
      check({tag, "_done"},  BW'(done), BW'(0));
      check({tag, "_start"}, BW'(pe_start), BW'(0));
      check({tag, "_pe_A"},  BW'(pe_a), BW'(0));
      check({tag, "_pe_B"},  pe_b, BW'(0));
      check({tag, "_max"},   BW'(max_score), BW'(0));
      check({tag, "_addr"},  BW'({a_addr, b_addr}), BW'(0));
   endtask

   task automatic run_job(input int mode, input bit abort);
      int waited;
      int done_cnt;
      plan_job(mode);
      check("idle_before_go", BW'(busy), BW'(0));
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("busy_after_go", BW'(busy), BW'(1));
      @(negedge clk);
      check("start_low_t2", BW'(pe_start), BW'(0));
      @(negedge clk);
      check("start_high_t3", BW'(pe_start), BW'(1));
      if (abort) begin
         repeat (20) @(negedge clk);
         #1 rst_n = 1'b0;
         #1 check_all_zero("mid_reset");
         exp_q.delete();
         plan_q.delete();
         exp_max_q.delete();
         exp_baddr_q.delete();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         done_cnt = 0;
         repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
         end
         check("no_done_after_reset", BW'(done_cnt), BW'(0));
         check("idle_after_reset", BW'(busy), BW'(0));
      end else begin
         waited = 0;
         while (!done) begin
            @(negedge clk);
            // Stray go pulses while busy must have no effect.
            go = busy && ($urandom_range(0, 15) == 0);
            waited++;
            if (waited > 20000) begin
               go = 1'b0;
               check("done_timeout", BW'(0), BW'(1));
               $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
               $finish;
            end
         end
         go = 1'b0;
         repeat (3) @(negedge clk);
         check("bases_left", BW'(exp_q.size()), BW'(0));
         check("max_held", BW'(max_score), BW'(last_max));
         check("busy_cleared", BW'(busy), BW'(0));
      end
   endtask

   initial begin : main
      for (int i = 0; i < int'(LEN_A); i++) a_mem[i] = 2'($urandom);
      for (int i = 0; i < int'(NS); i++) b_mem[i] = BW'({$urandom, $urandom, $urandom, $urandom});
      rst_n = 1'b0;
      go    = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_job(1, 1'b0);
      run_job(2, 1'b0);
      run_job(3, 1'b0);
      run_job(4, 1'b0);
      run_job(5, 1'b0);
      run_job(1, 1'b1);
      for (int j = 0; j < 4; j++) run_job(0, 1'b0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
